// File: rtl/wb_arbiter_if.sv
// Requester-side result channels and the registered writeback port of wb_arbiter.
// Modport slave is the arbiter's view; master is the view of the units and the register file.
interface wb_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0][4:0]  req_addr_i;
    logic [N_REQ-1:0][31:0] req_data_i;
    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic [4:0]             wb_addr_o;
    logic [31:0]            wb_data_o;
    logic                   wb_valid_o;
    logic                   wb_ready_i;
    logic [31:0]            contention_o;

    modport slave (
        input  req_addr_i, req_data_i, req_valid_i, wb_ready_i,
        output req_ready_o, wb_addr_o, wb_data_o, wb_valid_o, contention_o
    );

    modport master (
        output req_addr_i, req_data_i, req_valid_i, wb_ready_i,
        input  req_ready_o, wb_addr_o, wb_data_o, wb_valid_o, contention_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among N_REQ units,
// with a one-entry output register and a saturating contention counter.
module wb_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] last_r;
    logic [4:0]    wb_addr_r;
    logic [31:0]   wb_data_r;
    logic          wb_valid_r;
    logic [31:0]   contention_r;

    logic             can_load_s;
    logic             found_s;
    logic [PW-1:0]    winner_s;
    logic [PW-1:0]    idx_s;
    logic [3:0]       n_valid_s;
    logic             transfer_s;
    logic [N_REQ-1:0] ready_s;
    logic [4:0]       win_addr_s;
    logic [31:0]      win_data_s;

    assign can_load_s = !wb_valid_r || bus.wb_ready_i;

    // Search last+1 .. last (mod N_REQ) for the first valid requester; count valid requesters.
    always_comb begin
        found_s   = 1'b0;
        winner_s  = '0;
        idx_s     = '0;
        n_valid_s = 4'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_s = PW'((int'(last_r) + k) % N_REQ);
            if (!found_s && bus.req_valid_i[idx_s]) begin
                found_s  = 1'b1;
                winner_s = idx_s;
            end else begin
                found_s  = found_s;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            n_valid_s = n_valid_s + {3'b000, bus.req_valid_i[i]};
        end
    end

    // One-hot ready for the winner, suppressed under reset or backpressure.
    always_comb begin
        ready_s    = '0;
        transfer_s = 1'b0;
        win_addr_s = bus.req_addr_i[winner_s];
        win_data_s = bus.req_data_i[winner_s];
        if (can_load_s && found_s && !rst_i) begin
            ready_s[winner_s] = 1'b1;
            transfer_s        = 1'b1;
        end else begin
            ready_s    = '0;
            transfer_s = 1'b0;
        end
    end

    // Output register and round-robin pointer; x0 writes always carry zero data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_r <= 1'b0;
            wb_addr_r  <= 5'd0;
            wb_data_r  <= 32'd0;
            last_r     <= PW'(N_REQ - 1);
        end else if (transfer_s) begin
            wb_valid_r <= 1'b1;
            wb_addr_r  <= win_addr_s;
            wb_data_r  <= (win_addr_s == 5'd0) ? 32'd0 : win_data_s;
            last_r     <= winner_s;
        end else if (wb_valid_r && bus.wb_ready_i) begin
            wb_valid_r <= 1'b0;
        end else begin
            wb_valid_r <= wb_valid_r;
        end
    end

    // Saturating count of granted cycles with two or more valid requesters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            contention_r <= 32'd0;
        end else if (transfer_s && (n_valid_s >= 4'd2) && (contention_r != 32'hFFFF_FFFF)) begin
            contention_r <= contention_r + 32'd1;
        end else begin
            contention_r <= contention_r;
        end
    end

    assign bus.req_ready_o  = ready_s;
    assign bus.wb_addr_o    = wb_addr_r;
    assign bus.wb_data_o    = wb_data_r;
    assign bus.wb_valid_o   = wb_valid_r;
    assign bus.contention_o = contention_r;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with N_REQ=3.
`timescale 1ns/1ps
module tb_wb_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_arbiter_if #(.N_REQ(3)) bus ();

    wb_arbiter #(.N_REQ(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid_i = 3'b000;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;
        bus.wb_ready_i  = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clear_inputs();
        bus.req_valid_i = 3'b111;
        #2;
        check("rst_ready", 32'(bus.req_ready_o), 32'h0);
        check("rst_valid", 32'(bus.wb_valid_o), 32'h0);
        check("rst_addr", 32'(bus.wb_addr_o), 32'h0);
        check("rst_data", bus.wb_data_o, 32'h0);
        check("rst_cont", bus.contention_o, 32'h0);
        reset_dut();

        // single requester 1
        bus.req_valid_i   = 3'b010;
        bus.req_addr_i[1] = 5'd5;
        bus.req_data_i[1] = 32'h0000_1234;
        bus.wb_ready_i    = 1'b1;
        #1;
        check("t1_ready", 32'(bus.req_ready_o), 32'h2);
        step();
        bus.req_valid_i = 3'b000;
        check("t1_addr", 32'(bus.wb_addr_o), 32'd5);
        check("t1_data", bus.wb_data_o, 32'h0000_1234);
        check("t1_valid", 32'(bus.wb_valid_o), 32'h1);
        check("t1_cont", bus.contention_o, 32'h0);

        // all three held valid: rotation 0,1,2,0,1,2
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            bus.req_addr_i[i] = 5'(i + 1);
            bus.req_data_i[i] = 32'h100 + 32'(i);
        end
        bus.req_valid_i = 3'b111;
        bus.wb_ready_i  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("t2_ready", 32'(bus.req_ready_o), 32'h1 << (c % 3));
            step();
            check("t2_data", bus.wb_data_o, 32'h100 + 32'(c % 3));
        end
        bus.req_valid_i = 3'b000;
        check("t2_cont", bus.contention_o, 32'd6);

        // backpressure with requesters 0 and 2 valid, last = 0
        reset_dut();
        bus.req_addr_i[0] = 5'd7;
        bus.req_data_i[0] = 32'h0000_AAAA;
        bus.req_valid_i   = 3'b001;
        bus.wb_ready_i    = 1'b1;
        #1;
        check("t3_first", 32'(bus.req_ready_o), 32'h1);
        step();
        bus.wb_ready_i    = 1'b0;
        bus.req_addr_i[2] = 5'd9;
        bus.req_data_i[2] = 32'h0000_BBBB;
        bus.req_valid_i   = 3'b101;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t3_stall_ready", 32'(bus.req_ready_o), 32'h0);
            check("t3_stall_addr", 32'(bus.wb_addr_o), 32'd7);
            check("t3_stall_data", bus.wb_data_o, 32'h0000_AAAA);
            check("t3_stall_valid", 32'(bus.wb_valid_o), 32'h1);
            step();
        end
        bus.wb_ready_i = 1'b1;
        #1;
        check("t3_release_ready", 32'(bus.req_ready_o), 32'h4);
        step();
        bus.req_valid_i = 3'b000;
        check("t3_addr", 32'(bus.wb_addr_o), 32'd9);
        check("t3_data", bus.wb_data_o, 32'h0000_BBBB);
        check("t3_valid", 32'(bus.wb_valid_o), 32'h1);
        check("t3_cont", bus.contention_o, 32'd1);

        // write to x0 from requester 0 (last = 2)
        bus.req_addr_i[0] = 5'd0;
        bus.req_data_i[0] = 32'h0000_DEAD;
        bus.req_valid_i   = 3'b001;
        #1;
        check("t4_ready", 32'(bus.req_ready_o), 32'h1);
        step();
        bus.req_valid_i = 3'b000;
        check("t4_addr", 32'(bus.wb_addr_o), 32'd0);
        check("t4_data", bus.wb_data_o, 32'h0);
        check("t4_valid", 32'(bus.wb_valid_o), 32'h1);

        // asynchronous reset while the output register is full
        bus.wb_ready_i    = 1'b0;
        bus.req_addr_i[0] = 5'd4;
        bus.req_data_i[0] = 32'h0000_0044;
        bus.req_valid_i   = 3'b111;
        #1;
        check("t5_pre_valid", 32'(bus.wb_valid_o), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("t5_async_valid", 32'(bus.wb_valid_o), 32'h0);
        check("t5_async_ready", 32'(bus.req_ready_o), 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        bus.wb_ready_i = 1'b1;
        #1;
        check("t5_prio0", 32'(bus.req_ready_o), 32'h1);
        step();
        bus.req_valid_i = 3'b000;
        check("t5_addr", 32'(bus.wb_addr_o), 32'd4);
        check("t5_data", bus.wb_data_o, 32'h0000_0044);

        // contention counter saturation
        reset_dut();
        force dut.contention_r = 32'hFFFF_FFFE;
        #1;
        release dut.contention_r;
        #1;
        check("t6_preload", bus.contention_o, 32'hFFFF_FFFE);
        bus.req_valid_i = 3'b111;
        bus.wb_ready_i  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("t6_sat", bus.contention_o, 32'hFFFF_FFFF);
        end
        bus.req_valid_i = 3'b000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
